// File: rtl/serial_tasizan.sv
// rtl/serial_tasizan.sv - bit-serial adder, one full-adder stage plus carry flop, LSB first
module serial_tasizan #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, s_q, s_d;
  logic            carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic            fa_sum, fa_carry;

  always_comb begin
    fa_sum   = a_q[cnt_q] ^ b_q[cnt_q] ^ carry_q;
    fa_carry = (a_q[cnt_q] & b_q[cnt_q]) | (carry_q & (a_q[cnt_q] ^ b_q[cnt_q]));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[cnt_q] = fa_sum;
        carry_d      = fa_carry;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB, so overflow is its xor with carry out
          state_d = DONE;
          cnt_d   = '0;
          s_d     = sum_d;
          cout_d  = fa_carry;
          ovf_d   = carry_q ^ fa_carry;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_tasizan.sv
// tb/tb_serial_tasizan.sv - directed self-checking bench for serial_tasizan, WIDTH=8 and WIDTH=1
module tb_serial_tasizan;

  logic       clk = 1'b0;
  logic       rst8, start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, s8;
  logic       rst1, start1, cin1, busy1, done1, cout1, ovf1;
  logic [0:0] a1, b1, s1;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  serial_tasizan #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
  );

  serial_tasizan #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // glitch_at >= 0 pulses start with all-ones operands during that RUN cycle
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                      input logic [7:0] es, input logic ec, input logic eo, input int glitch_at);
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = ci; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq("busy_run", busy8, 1);
      check_eq("done_run", done8, 0);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      start8 = 1'b0;
      if (i == glitch_at) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end
      step();
    end
    start8 = 1'b0;
    check_eq("done_pulse", done8, 1);
    check_eq("busy_done", busy8, 0);
    check_eq("sum", s8, es);
    check_eq("cout", cout8, ec);
    check_eq("ovf", ovf8, eo);
    step();
    check_eq("done_clear", done8, 0);
    check_eq("sum_hold", s8, es);
  endtask

  initial begin
    int done_seen;
    logic [1:0] fa;
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    step(); step();
    rst8 = 1'b0; rst1 = 1'b0;
    check_eq("rst_busy", busy8, 0);
    check_eq("rst_done", done8, 0);
    check_eq("rst_s", s8, 0);
    check_eq("rst_cout", cout8, 0);
    check_eq("rst_ovf", ovf8, 0);
    check_eq("rst_busy1", busy1, 0);

    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1);
    run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, -1);
    run8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, -1);
    run8(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0, -1);
    run8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 3);

    // reset in the middle of a run aborts it
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    repeat (4) step();
    rst8 = 1'b1;
    step();
    rst8 = 1'b0;
    check_eq("abort_busy", busy8, 0);
    check_eq("abort_done", done8, 0);
    check_eq("abort_s", s8, 0);
    check_eq("abort_cout", cout8, 0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) done_seen++;
      step();
    end
    check_eq("abort_no_done", done_seen, 0);

    // reset wins over start in the same cycle
    @(negedge clk);
    rst8 = 1'b1; start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
    step();
    rst8 = 1'b0; start8 = 1'b0;
    check_eq("rst_prio_busy", busy8, 0);

    // start held high: back-to-back operations with no idle cycle
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    step();
    a8 = 8'h03; b8 = 8'h04;
    repeat (7) step();
    check_eq("b2b_busy_last", busy8, 1);
    step();
    check_eq("b2b_done1", done8, 1);
    check_eq("b2b_s1", s8, 8'h03);
    step();
    start8 = 1'b0;
    check_eq("b2b_no_idle", busy8, 1);
    check_eq("b2b_s_hold", s8, 8'h03);
    repeat (7) step();
    check_eq("b2b_gap_quiet", done8, 0);
    step();
    check_eq("b2b_done2", done8, 1);
    check_eq("b2b_s2", s8, 8'h07);
    check_eq("b2b_cout2", cout8, 0);
    step();

    // WIDTH=1 acts as a registered full adder
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      fa = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      step();
      start1 = 1'b0;
      check_eq("w1_busy", busy1, 1);
      step();
      check_eq("w1_done", done1, 1);
      check_eq("w1_sum", {cout1, s1}, fa);
      check_eq("w1_ovf", ovf1, v[0] ^ fa[1]);
      step();
      check_eq("w1_idle", done1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_tasizan.md
SERIAL_TASIZAN -- requirements
Module: serial_tasizan

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-006 b  input  WIDTH  operand B.
REQ-007 cin  input  1  carry-in.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse, result valid.
REQ-010 s  output  WIDTH  sum, registered.
REQ-011 cout  output  1  carry-out of MSB, registered.
REQ-012 ovf  output  1  signed overflow flag, registered.

Function
REQ-013 The block SHALL compute {cout,s} = a + b + cin bit-serially, LSB first, using one full-adder stage and a carry flip-flop.
REQ-014 FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-015 In IDLE or DONE, start=1 at an edge SHALL latch a, b, load carry flip-flop with cin, clear bit counter, and enter RUN.
REQ-016 In IDLE with start=0 the FSM SHALL remain in IDLE; in DONE with start=0 it SHALL go to IDLE.
REQ-017 In RUN, each edge SHALL process bit index = counter, store sum bit at that index of an internal shift register, update carry, increment counter.
REQ-018 On the edge processing bit WIDTH-1, FSM SHALL enter DONE and update s, cout, ovf in the same edge.
REQ-019 ovf SHALL equal carry into MSB XOR carry out of MSB.
REQ-020 Latency: start accepted at edge 0 -> done high for exactly the cycle after edge WIDTH, i.e. WIDTH cycles of busy, then one done cycle.
REQ-021 busy SHALL be 1 exactly while in RUN; done SHALL be 1 exactly while in DONE.
REQ-022 start while in RUN SHALL be ignored; latched operands SHALL not change.
REQ-023 a, b, cin changes after acceptance SHALL not affect the result.
REQ-024 s, cout, ovf SHALL hold their last result through IDLE and RUN until the next DONE entry.
REQ-025 start asserted in DONE SHALL begin the next operation with no IDLE cycle (back-to-back throughput one result per WIDTH+1 cycles).
REQ-026 WIDTH=1 SHALL behave as a registered full adder: busy one cycle, done next cycle.
REQ-027 Counter width SHALL be sufficient for WIDTH-1 with no wrap before DONE.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, busy=0, done=0, s=0, cout=0, ovf=0, carry=0, counter=0.
REQ-029 rst SHALL take priority over start in the same cycle.
REQ-030 rst mid-RUN SHALL abort the operation; no done pulse SHALL follow for it.

Verification
REQ-031 WIDTH=8: a=8'hFF, b=8'h01, cin=0, start pulse -> busy 8 cycles, done next cycle, s=8'h00, cout=1, ovf=0.
REQ-032 WIDTH=8: a=8'h7F, b=8'h01, cin=0 -> s=8'h80, cout=0, ovf=1; a=8'h80, b=8'h80, cin=1 -> s=8'h01, cout=1, ovf=1.
REQ-033 WIDTH=1: all 8 combinations of a,b,cin -> {cout,s} matches full-adder truth table (e.g. 1,1,1 -> cout=1, s=1).
REQ-034 WIDTH=8: start a=8'h10,b=8'h20; at RUN cycle 3 pulse start with a=8'hFF,b=8'hFF -> ignored, s=8'h30, cout=0.
REQ-035 WIDTH=8: rst at RUN cycle 4 -> next cycle busy=0, done=0, s=0, cout=0; no done pulse until a new start.
REQ-036 WIDTH=8: hold start=1 with a=8'h01,b=8'h02 then a=8'h03,b=8'h04 -> done pulses 9 cycles apart, s=8'h03 then 8'h07, no IDLE cycle between.
